// File: rtl/pipeline_hazard_scoreboard.sv
// rtl/pipeline_hazard_scoreboard.sv - issue-side hazard scoreboard: stall/bubble, forwarding selects,
// multi-cycle EX freeze and saturating stall-cycle counter.
module pipeline_hazard_scoreboard #(
    parameter int REG_ADDR_W  = 5,
    parameter int WB_DEPTH    = 3,
    parameter int FWD_EN      = 1,
    parameter int MC_CNT_W    = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            issue_valid,
    input  logic [REG_ADDR_W-1:0]           issue_rs1,
    input  logic [REG_ADDR_W-1:0]           issue_rs2,
    input  logic                            issue_rs1_used,
    input  logic                            issue_rs2_used,
    input  logic [REG_ADDR_W-1:0]           issue_rd,
    input  logic                            issue_wr_en,
    input  logic                            issue_is_load,
    input  logic [MC_CNT_W-1:0]             issue_mc_cycles,
    input  logic                            flush,
    output logic                            fetch_en,
    output logic                            decode_latch_en,
    output logic                            pipe_en,
    output logic                            bubble,
    output logic [$clog2(WB_DEPTH+1)-1:0]   fwd_sel_rs1,
    output logic [$clog2(WB_DEPTH+1)-1:0]   fwd_sel_rs2,
    output logic                            mc_busy,
    output logic [STALL_CNT_W-1:0]          stall_cycles
);

    localparam int FSEL_W = $clog2(WB_DEPTH+1);

    logic [WB_DEPTH-1:0]   ent_valid;
    logic [WB_DEPTH-1:0]   ent_load;
    logic [REG_ADDR_W-1:0] ent_rd [WB_DEPTH];
    logic [MC_CNT_W-1:0]   mc_cnt;

    logic                  mc_active;
    logic                  stall;
    logic                  accept;
    logic [REG_ADDR_W-1:0] src      [2];
    logic                  src_used [2];
    logic                  haz      [2];
    logic [FSEL_W-1:0]     sel      [2];

    assign mc_active   = (mc_cnt != '0);
    assign src[0]      = issue_rs1;
    assign src[1]      = issue_rs2;
    assign src_used[0] = issue_rs1_used;
    assign src_used[1] = issue_rs2_used;

    // Scan oldest to youngest so the youngest matching entry has the final say.
    // The op frozen in EX cannot forward until its last EX cycle (mc_cnt == 0).
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            haz[s] = 1'b0;
            sel[s] = '0;
            for (int k = WB_DEPTH-1; k >= 0; k--) begin
                if (src_used[s] && (src[s] != '0) && ent_valid[k] && (ent_rd[k] == src[s])) begin
                    if ((FWD_EN == 0) || ((k == 0) && (ent_load[k] || mc_active))) begin
                        haz[s] = 1'b1;
                        sel[s] = '0;
                    end else begin
                        haz[s] = 1'b0;
                        sel[s] = FSEL_W'(k + 1);
                    end
                end
            end
        end
    end

    assign stall  = issue_valid && !flush && (haz[0] || haz[1]);
    assign accept = issue_valid && !flush && !stall;

    always_comb begin
        fetch_en        = 1'b0;
        decode_latch_en = 1'b0;
        pipe_en         = 1'b0;
        bubble          = 1'b0;
        mc_busy         = 1'b0;
        fwd_sel_rs1     = '0;
        fwd_sel_rs2     = '0;
        if (!rst) begin
            mc_busy         = mc_active;
            pipe_en         = !mc_active;
            fetch_en        = !stall && !mc_active;
            decode_latch_en = !stall && !mc_active;
            bubble          = !mc_active && (stall || flush || !issue_valid);
            fwd_sel_rs1     = sel[0];
            fwd_sel_rs2     = sel[1];
        end
    end

    // While a multi-cycle op holds EX the tracked stages freeze; a concurrent
    // flush only concerns the younger op in decode, so it has nothing to kill here.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid <= '0;
            mc_cnt    <= '0;
        end else if (!mc_active) begin
            for (int k = 1; k < WB_DEPTH; k++) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_load[k]  <= ent_load[k-1];
                ent_rd[k]    <= ent_rd[k-1];
            end
            ent_valid[0] <= accept && issue_wr_en;
            ent_load[0]  <= issue_is_load;
            ent_rd[0]    <= issue_rd;
            if (accept) begin
                mc_cnt <= issue_mc_cycles;
            end
        end else begin
            mc_cnt <= mc_cnt - MC_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if ((stall || mc_active) && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// tb/tb_pipeline_hazard_scoreboard.sv - randomized + directed bench for pipeline_hazard_scoreboard
// across three configurations (default, no forwarding, 2-bit stall counter).
module tb_pipeline_hazard_scoreboard;

    localparam int D = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid, issue_rs1_used, issue_rs2_used, issue_wr_en, issue_is_load, flush;
    logic [4:0] issue_rs1, issue_rs2, issue_rd;
    logic [3:0] issue_mc_cycles;

    always #5 clk = ~clk;

    logic        fe0, fe1, fe2, dl0, dl1, dl2, pe0, pe1, pe2, bb0, bb1, bb2, mb0, mb1, mb2;
    logic [1:0]  f10, f11, f12, f20, f21, f22;
    logic [15:0] sc0, sc1;
    logic [1:0]  sc2;

    pipeline_hazard_scoreboard u0 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used), .issue_rd(issue_rd),
        .issue_wr_en(issue_wr_en), .issue_is_load(issue_is_load), .issue_mc_cycles(issue_mc_cycles),
        .flush(flush), .fetch_en(fe0), .decode_latch_en(dl0), .pipe_en(pe0), .bubble(bb0),
        .fwd_sel_rs1(f10), .fwd_sel_rs2(f20), .mc_busy(mb0), .stall_cycles(sc0));

    pipeline_hazard_scoreboard #(.FWD_EN(0)) u1 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used), .issue_rd(issue_rd),
        .issue_wr_en(issue_wr_en), .issue_is_load(issue_is_load), .issue_mc_cycles(issue_mc_cycles),
        .flush(flush), .fetch_en(fe1), .decode_latch_en(dl1), .pipe_en(pe1), .bubble(bb1),
        .fwd_sel_rs1(f11), .fwd_sel_rs2(f21), .mc_busy(mb1), .stall_cycles(sc1));

    pipeline_hazard_scoreboard #(.STALL_CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used), .issue_rd(issue_rd),
        .issue_wr_en(issue_wr_en), .issue_is_load(issue_is_load), .issue_mc_cycles(issue_mc_cycles),
        .flush(flush), .fetch_en(fe2), .decode_latch_en(dl2), .pipe_en(pe2), .bubble(bb2),
        .fwd_sel_rs1(f12), .fwd_sel_rs2(f22), .mc_busy(mb2), .stall_cycles(sc2));

    // Model: list of in-flight register writers per configuration, each with its stage position.
    typedef struct {
        int       inst;
        logic [4:0] rd;
        bit       ld;
        int       pos;
    } rec_t;

    rec_t q[$];
    int   mc_rem[3];
    int   scnt[3];
    int   fwd_en_m[3] = '{1, 0, 1};
    int   smax[3]     = '{65535, 65535, 3};

    int total = 0;
    int bad   = 0;

    logic [31:0] lfe[3], lpe[3], lbb[3], lmb[3], lf1[3], lf2[3], lsc[3], ldl[3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void resolve(input int i, input bit used, input logic [4:0] s, input bit busy,
                                    output bit haz, output int sel);
        int best;
        bit ld;
        best = D;
        ld   = 1'b0;
        haz  = 1'b0;
        sel  = 0;
        if (used && s != 5'd0) begin
            foreach (q[j]) begin
                if (q[j].inst == i && q[j].rd == s && q[j].pos < best) begin
                    best = q[j].pos;
                    ld   = q[j].ld;
                end
            end
            if (best < D) begin
                if (fwd_en_m[i] == 0 || (best == 0 && (ld || busy))) haz = 1'b1;
                else sel = best + 1;
            end
        end
    endfunction

    task automatic step();
        bit busy[3];
        bit st[3];
        bit acc[3];
        @(negedge clk);
        lfe = '{32'(fe0), 32'(fe1), 32'(fe2)};
        ldl = '{32'(dl0), 32'(dl1), 32'(dl2)};
        lpe = '{32'(pe0), 32'(pe1), 32'(pe2)};
        lbb = '{32'(bb0), 32'(bb1), 32'(bb2)};
        lmb = '{32'(mb0), 32'(mb1), 32'(mb2)};
        lf1 = '{32'(f10), 32'(f11), 32'(f12)};
        lf2 = '{32'(f20), 32'(f21), 32'(f22)};
        lsc = '{32'(sc0), 32'(sc1), 32'(sc2)};
        for (int i = 0; i < 3; i++) begin
            bit h1, h2;
            int s1, s2;
            busy[i] = (mc_rem[i] != 0);
            resolve(i, issue_rs1_used, issue_rs1, busy[i], h1, s1);
            resolve(i, issue_rs2_used, issue_rs2, busy[i], h2, s2);
            st[i]  = issue_valid && !flush && (h1 || h2);
            acc[i] = issue_valid && !flush && !st[i];
            chk($sformatf("fetch_en[%0d]", i), lfe[i], 32'(!rst && !st[i] && !busy[i]));
            chk($sformatf("decode_latch_en[%0d]", i), ldl[i], 32'(!rst && !st[i] && !busy[i]));
            chk($sformatf("pipe_en[%0d]", i), lpe[i], 32'(!rst && !busy[i]));
            chk($sformatf("bubble[%0d]", i), lbb[i], 32'(!rst && !busy[i] && (st[i] || flush || !issue_valid)));
            chk($sformatf("mc_busy[%0d]", i), lmb[i], 32'(!rst && busy[i]));
            if (rst || !h1) chk($sformatf("fwd_sel_rs1[%0d]", i), lf1[i], rst ? 0 : s1);
            if (rst || !h2) chk($sformatf("fwd_sel_rs2[%0d]", i), lf2[i], rst ? 0 : s2);
            chk($sformatf("stall_cycles[%0d]", i), lsc[i], scnt[i]);
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            mc_rem = '{0, 0, 0};
            scnt   = '{0, 0, 0};
        end else begin
            for (int i = 0; i < 3; i++) begin
                if ((st[i] || busy[i]) && scnt[i] < smax[i]) scnt[i]++;
                if (!busy[i]) begin
                    foreach (q[j]) if (q[j].inst == i) q[j].pos = q[j].pos + 1;
                    if (acc[i] && issue_wr_en) begin
                        rec_t r;
                        r.inst = i;
                        r.rd   = issue_rd;
                        r.ld   = issue_is_load;
                        r.pos  = 0;
                        q.push_back(r);
                    end
                    mc_rem[i] = acc[i] ? int'(issue_mc_cycles) : 0;
                end else begin
                    mc_rem[i]--;
                end
            end
            for (int j = q.size() - 1; j >= 0; j--) if (q[j].pos >= D) q.delete(j);
        end
        #1;
    endtask

    task automatic drv(input bit v, input logic [4:0] a, input bit ua, input logic [4:0] b, input bit ub,
                       input logic [4:0] d, input bit w, input bit l, input logic [3:0] m, input bit f);
        issue_valid = v;  issue_rs1 = a;  issue_rs1_used = ua;  issue_rs2 = b;  issue_rs2_used = ub;
        issue_rd = d;  issue_wr_en = w;  issue_is_load = l;  issue_mc_cycles = m;  flush = f;
        step();
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int base;

    initial begin
        rst = 1'b1;
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rs1_used = 0; issue_rs2_used = 0;
        issue_rd = 0; issue_wr_en = 0; issue_is_load = 0; issue_mc_cycles = 0; flush = 0;
        mc_rem = '{0, 0, 0};
        scnt   = '{0, 0, 0};

        idle(2);
        chk("rst_fetch_en", lfe[0], 0);
        chk("rst_pipe_en", lpe[0], 0);
        chk("rst_bubble", lbb[0], 0);
        rst = 1'b0;
        idle(1);
        chk("post_rst_fetch_en", lfe[0], 1);
        chk("post_rst_pipe_en", lpe[0], 1);
        chk("post_rst_stall_cycles", lsc[0], 0);

        // forward from EX
        drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("fwd_ex_sel", lf1[0], 1);
        chk("fwd_ex_fetch", lfe[0], 1);
        chk("nofwd_stall_fetch", lfe[1], 0);

        // no-forwarding config stalls until the writer leaves writeback
        idle(3);
        drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            drv(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("nofwd_fetch_c%0d", c), lfe[1], (c == 3) ? 1 : 0);
            chk($sformatf("fwd_walk_c%0d", c), lf1[0], (c < 3) ? c + 1 : 0);
        end
        chk("nofwd_sel_after", lf1[1], 0);

        // load-use
        idle(3);
        drv(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
        drv(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        chk("load_use_fetch", lfe[0], 0);
        chk("load_use_bubble", lbb[0], 1);
        drv(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        chk("load_fwd_sel", lf2[0], 2);
        chk("load_fwd_fetch", lfe[0], 1);
        chk("load_stall_count", lsc[0], 1);

        // multi-cycle freeze
        idle(3);
        drv(1, 0, 0, 0, 0, 10, 1, 0, 4, 0);
        base = int'(lsc[0]);
        for (int c = 0; c < 4; c++) begin
            drv(1, 10, 1, 0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("mc_busy_c%0d", c), lmb[0], 1);
            chk($sformatf("mc_fetch_c%0d", c), lfe[0], 0);
        end
        drv(1, 10, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("mc_release_busy", lmb[0], 0);
        chk("mc_release_fetch", lfe[0], 1);
        chk("mc_release_fwd", lf1[0], 1);
        chk("mc_stall_count", lsc[0], base + 4);

        // flush beats hazard; flushed op leaves no entry
        idle(3);
        drv(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
        drv(1, 9, 1, 0, 0, 11, 1, 0, 0, 1);
        chk("flush_fetch", lfe[0], 1);
        chk("flush_bubble", lbb[0], 1);
        drv(1, 11, 1, 9, 1, 0, 0, 0, 0, 0);
        chk("flushed_no_fwd", lf1[0], 0);
        chk("older_load_fwd", lf2[0], 2);

        // x0 never hazards
        drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        drv(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        chk("x0_sel1", lf1[0], 0);
        chk("x0_sel2", lf2[0], 0);
        chk("x0_nofwd_fetch", lfe[1], 1);

        // reset mid multi-cycle
        idle(3);
        drv(1, 0, 0, 0, 0, 12, 1, 0, 4, 0);
        idle(2);
        rst = 1'b1;
        idle(1);
        chk("rst_mc_busy_forced", lmb[0], 0);
        rst = 1'b0;
        drv(1, 12, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_abort_busy", lmb[0], 0);
        chk("rst_abort_fwd", lf1[0], 0);
        chk("rst_abort_fetch", lfe[0], 1);
        for (int i = 0; i < 3; i++) chk($sformatf("rst_abort_count[%0d]", i), lsc[i], 0);

        // 5 stall cycles: 4 freeze + 1 load-use; 2-bit counter saturates at 3
        drv(1, 0, 0, 0, 0, 13, 1, 0, 4, 0);
        idle(4);
        drv(1, 0, 0, 0, 0, 14, 1, 1, 0, 0);
        drv(1, 0, 0, 14, 1, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 14, 1, 0, 0, 0, 0, 0);
        chk("sat_count_wide", lsc[0], 5);
        chk("sat_count_narrow", lsc[2], 3);

        // randomized phase, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            rst             = ($urandom_range(0, 99) == 0);
            issue_valid     = ($urandom_range(0, 3) != 0);
            issue_rs1       = 5'($urandom_range(0, 7));
            issue_rs2       = 5'($urandom_range(0, 7));
            issue_rs1_used  = ($urandom_range(0, 3) != 0);
            issue_rs2_used  = ($urandom_range(0, 1) != 0);
            issue_rd        = 5'($urandom_range(0, 7));
            issue_wr_en     = ($urandom_range(0, 3) != 0);
            issue_is_load   = ($urandom_range(0, 3) == 0);
            issue_mc_cycles = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 5)) : 4'd0;
            flush           = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
